// File: rtl/spi_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_pkg                                                          |
// | Purpose  : Shared SPI master types: FSM state encoding and mode constants.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

    // SPI mode 0: SCLK idles low, data sampled on the rising edge
    localparam logic c_cpol = 1'b0;
    localparam logic c_cpha = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_master_if                                                    |
// | Purpose  : Control and serial-line bundle between SPI master and its user.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic              en_i;
    logic [DATA_W-1:0] tx_data_i;
    logic              sdi_i;
    logic              sdo_o;
    logic              sclk_o;
    logic              ss_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              done_o;
    logic              busy_o;

    modport master (
        input  en_i, tx_data_i, sdi_i,
        output sdo_o, sclk_o, ss_o, rx_data_o, done_o, busy_o
    );

    modport slave (
        output en_i, tx_data_i, sdi_i,
        input  sdo_o, sclk_o, ss_o, rx_data_o, done_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/spi_clk_div.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_clk_div                                                      |
// | Purpose  : Half-period counter giving phase ticks and SCLK rise/fall strobes.|
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_clk_div #(
    parameter int HALF_DIV = 2
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic i_run,
    input  wire logic i_shift,
    output logic      o_tick,
    output logic      o_rise,
    output logic      o_fall
);
    localparam logic [7:0] c_last = 8'(HALF_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_phase;
    logic       w_tick;

    assign w_tick = i_run && (r_cnt == c_last);

    // Counter restarts on every tick so each FSM phase spans whole half-periods
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            if (!i_run || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (!i_shift) begin
                r_phase <= 1'b0;
            end else if (w_tick) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign o_tick = w_tick;
    assign o_rise = w_tick && i_shift && !r_phase;
    assign o_fall = w_tick && i_shift &&  r_phase;

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_master                                                       |
// | Purpose  : Mode-0 SPI master, MSB first, back-to-back frames while enabled. |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 2
) (
    input  wire logic    clk_i,
    input  wire logic    rst_ni,
    spi_master_if.master bus
);
    localparam int                c_bw   = $clog2(DATA_W + 1);
    localparam logic [c_bw-1:0]   c_bits = c_bw'(DATA_W);

    spi_state_e        r_state, w_state;
    logic [DATA_W-1:0] r_tx_sh, w_tx_sh;
    logic [DATA_W-1:0] r_rx_sh, w_rx_sh;
    logic [c_bw-1:0]   r_bit,   w_bit;
    logic              r_sdo,   w_sdo;
    logic              r_sclk,  w_sclk;
    logic              r_ss,    w_ss;
    logic [DATA_W-1:0] r_rx,    w_rx;
    logic              r_done,  w_done;
    logic              r_busy,  w_busy;

    logic w_tick, w_rise, w_fall;

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_run   (r_state != IDLE),
        .i_shift ((r_state == LEAD) || (r_state == SHIFT)),
        .o_tick  (w_tick),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_bit   <= '0;
            r_sdo   <= 1'b0;
            r_sclk  <= c_cpol;
            r_ss    <= 1'b1;
            r_rx    <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tx_sh <= w_tx_sh;
            r_rx_sh <= w_rx_sh;
            r_bit   <= w_bit;
            r_sdo   <= w_sdo;
            r_sclk  <= w_sclk;
            r_ss    <= w_ss;
            r_rx    <= w_rx;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    always_comb begin
        w_state = r_state;
        w_tx_sh = r_tx_sh;
        w_rx_sh = r_rx_sh;
        w_bit   = r_bit;
        w_sdo   = r_sdo;
        w_sclk  = r_sclk;
        w_ss    = r_ss;
        w_rx    = r_rx;
        w_done  = 1'b0;

        case (r_state)
            IDLE: begin
                w_ss   = 1'b1;
                w_sclk = c_cpol;
                w_sdo  = 1'b0;
                if (bus.en_i) begin
                    w_state = LEAD;
                    w_tx_sh = bus.tx_data_i;
                    w_sdo   = bus.tx_data_i[DATA_W-1];
                    w_rx_sh = '0;
                    w_bit   = '0;
                    w_ss    = 1'b0;
                end
            end
            LEAD: begin
                if (w_rise) begin
                    w_state = SHIFT;
                    w_sclk  = 1'b1;
                    w_rx_sh = {r_rx_sh[DATA_W-2:0], bus.sdi_i};
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    // After the last fall the low half-period runs out before TRAIL
                    if (r_bit == c_bits) begin
                        w_state = TRAIL;
                    end else begin
                        w_sclk  = 1'b1;
                        w_rx_sh = {r_rx_sh[DATA_W-2:0], bus.sdi_i};
                    end
                end else if (w_fall) begin
                    w_sclk = 1'b0;
                    w_bit  = r_bit + 1'b1;
                    if (r_bit != c_bits - 1'b1) begin
                        w_tx_sh = r_tx_sh << 1;
                        w_sdo   = r_tx_sh[DATA_W-2];
                    end
                end
            end
            TRAIL: begin
                if (w_tick) begin
                    w_state = GAP;
                    w_ss    = 1'b1;
                    w_sdo   = 1'b0;
                    w_rx    = r_rx_sh;
                    w_done  = 1'b1;
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    assign bus.sdo_o     = r_sdo;
    assign bus.sclk_o    = r_sclk;
    assign bus.ss_o      = r_ss;
    assign bus.rx_data_o = r_rx;
    assign bus.done_o    = r_done;
    assign bus.busy_o    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_master                                                    |
// | Purpose  : Directed self-checking bench for spi_master (DATA_W=8, HALF=2).  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master;
    localparam int DATA_W   = 8;
    localparam int HALF_DIV = 2;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic loopback = 1'b0;
    logic sdi_drv  = 1'b0;

    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(DATA_W)) bus ();
    assign bus.sdi_i = loopback ? bus.sdo_o : sdi_drv;

    spi_master #(
        .DATA_W   (DATA_W),
        .HALF_DIV (HALF_DIV)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int          cyc;
    int          n_ssf, n_ssr, n_rise, n_fall, n_done;
    int          ssf_t [4];
    int          ssr_t [4];
    int          rise_t[32];
    int          fall_t[32];
    logic [31:0] bits;
    logic [7:0]  rx_at [4];
    logic        timed_out;

    // Steps cycles recording SPI line events until nframes frames have ended
    task automatic capture(input int nframes, input int drop_rises, input int tx_rises,
                           input logic [7:0] tx_next, input int max_cycles);
        logic p_ss, p_sclk, dropped, swapped;
        cyc = 0; n_ssf = 0; n_ssr = 0; n_rise = 0; n_fall = 0; n_done = 0;
        bits = '0; timed_out = 1'b1; dropped = 1'b0; swapped = 1'b0;
        p_ss = bus.ss_o; p_sclk = bus.sclk_o;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (p_ss && !bus.ss_o) begin if (n_ssf < 4) ssf_t[n_ssf] = cyc; n_ssf++; end
            if (!p_ss && bus.ss_o) begin if (n_ssr < 4) ssr_t[n_ssr] = cyc; n_ssr++; end
            if (!p_sclk && bus.sclk_o) begin
                if (n_rise < 32) rise_t[n_rise] = cyc;
                n_rise++;
                bits = {bits[30:0], bus.sdo_o};
            end
            if (p_sclk && !bus.sclk_o) begin if (n_fall < 32) fall_t[n_fall] = cyc; n_fall++; end
            if (bus.done_o) begin if (n_done < 4) rx_at[n_done] = bus.rx_data_o; n_done++; end
            p_ss = bus.ss_o; p_sclk = bus.sclk_o;
            if (!dropped && n_rise >= drop_rises) begin bus.en_i = 1'b0; dropped = 1'b1; end
            if (!swapped && n_rise >= tx_rises) begin bus.tx_data_i = tx_next; swapped = 1'b1; end
            if (n_ssr >= nframes && !bus.busy_o) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        bus.en_i = 1'b1; bus.tx_data_i = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({bus.ss_o, bus.sclk_o, bus.sdo_o, bus.done_o, bus.busy_o} !== 5'b10000) begin
                miscompares++;
                $display("FAIL reset_outputs cyc%0d: got ss,sclk,sdo,done,busy=%b required 10000", i,
                         {bus.ss_o, bus.sclk_o, bus.sdo_o, bus.done_o, bus.busy_o});
            end
        end
        vectors++;
        if (bus.rx_data_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rx: got %h required 00", bus.rx_data_o);
        end
        bus.en_i = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.ss_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got ss=%b busy=%b required ss=1 busy=0", bus.ss_o, bus.busy_o);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp;
        exp = 8'hA5;
        loopback = 1'b1; bus.tx_data_i = exp; bus.en_i = 1'b1;
        capture(1, 0, 99, 8'h00, 200);
        vectors++;
        if (timed_out) begin miscompares++; $display("FAIL loopback_complete: got timeout required frame end"); end
        vectors++;
        if (ssf_t[0] !== 1) begin miscompares++; $display("FAIL loopback_start: got ss fall at cycle %0d required 1", ssf_t[0]); end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bits[7-k] !== exp[7-k]) begin
                miscompares++;
                $display("FAIL loopback_sdo bit%0d: got %b required %b", k, bits[7-k], exp[7-k]);
            end
        end
        vectors++;
        if (n_done !== 1) begin miscompares++; $display("FAIL loopback_done_count: got %0d required 1", n_done); end
        vectors++;
        if (rx_at[0] !== 8'hA5) begin miscompares++; $display("FAIL loopback_rx: got %h required a5", rx_at[0]); end
    endtask

    task automatic test_timing();
        loopback = 1'b0; sdi_drv = 1'b1; bus.tx_data_i = 8'h5A; bus.en_i = 1'b1;
        capture(1, 0, 99, 8'h00, 200);
        vectors++;
        if (timed_out) begin miscompares++; $display("FAIL timing_complete: got timeout required frame end"); end
        vectors++;
        if (ssr_t[0] - ssf_t[0] !== 36) begin miscompares++; $display("FAIL timing_ss_low: got %0d required 36", ssr_t[0] - ssf_t[0]); end
        vectors++;
        if (rise_t[0] - ssf_t[0] !== 2) begin miscompares++; $display("FAIL timing_first_rise: got %0d required 2", rise_t[0] - ssf_t[0]); end
        vectors++;
        if (n_rise !== 8 || n_fall !== 8) begin
            miscompares++;
            $display("FAIL timing_edge_count: got rises=%0d falls=%0d required 8/8", n_rise, n_fall);
        end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (rise_t[k+1] - rise_t[k] !== 4) begin
                miscompares++;
                $display("FAIL timing_period%0d: got %0d required 4", k, rise_t[k+1] - rise_t[k]);
            end
        end
        vectors++;
        if (fall_t[7] - rise_t[7] !== 2) begin miscompares++; $display("FAIL timing_high_half: got %0d required 2", fall_t[7] - rise_t[7]); end
        vectors++;
        if (rx_at[0] !== 8'hFF) begin miscompares++; $display("FAIL timing_rx_ones: got %h required ff", rx_at[0]); end
    endtask

    task automatic test_early_drop();
        int idle_bad;
        loopback = 1'b0; sdi_drv = 1'b0; bus.tx_data_i = 8'h96; bus.en_i = 1'b1;
        capture(1, 3, 99, 8'h00, 200);
        vectors++;
        if (timed_out) begin miscompares++; $display("FAIL early_drop_complete: got timeout required frame end"); end
        vectors++;
        if (n_rise !== 8 || n_done !== 1) begin
            miscompares++;
            $display("FAIL early_drop_frame: got rises=%0d dones=%0d required 8/1", n_rise, n_done);
        end
        vectors++;
        if (rx_at[0] !== 8'h00) begin miscompares++; $display("FAIL early_drop_rx: got %h required 00", rx_at[0]); end
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.busy_o !== 1'b0 || bus.ss_o !== 1'b1) idle_bad++;
        end
        vectors++;
        if (idle_bad !== 0) begin miscompares++; $display("FAIL early_drop_idle: got %0d busy cycles required 0", idle_bad); end
    endtask

    task automatic test_back_to_back();
        loopback = 1'b1; bus.tx_data_i = 8'h3C; bus.en_i = 1'b1;
        capture(2, 11, 1, 8'hC3, 300);
        vectors++;
        if (timed_out) begin miscompares++; $display("FAIL b2b_complete: got timeout required two frames"); end
        vectors++;
        if (n_done !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d required 2", n_done); end
        vectors++;
        if (rx_at[0] !== 8'h3C) begin miscompares++; $display("FAIL b2b_rx0: got %h required 3c", rx_at[0]); end
        vectors++;
        if (rx_at[1] !== 8'hC3) begin miscompares++; $display("FAIL b2b_rx1: got %h required c3", rx_at[1]); end
        vectors++;
        if (ssf_t[1] - ssr_t[0] !== 3) begin miscompares++; $display("FAIL b2b_gap: got %0d required 3", ssf_t[1] - ssr_t[0]); end
        vectors++;
        if (ssr_t[1] - ssf_t[1] !== 36) begin miscompares++; $display("FAIL b2b_frame2_len: got %0d required 36", ssr_t[1] - ssf_t[1]); end
        vectors++;
        if (bits[15:0] !== 16'h3CC3) begin miscompares++; $display("FAIL b2b_sdo: got %h required 3cc3", bits[15:0]); end
    endtask

    task automatic test_abort();
        int done_seen;
        loopback = 1'b1; bus.tx_data_i = 8'hFF; bus.en_i = 1'b1;
        repeat (16) begin @(posedge clk); #1; end
        vectors++;
        if (bus.busy_o !== 1'b1 || bus.ss_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_midframe: got busy=%b ss=%b required 1/0", bus.busy_o, bus.ss_o);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.ss_o, bus.sclk_o, bus.sdo_o, bus.done_o, bus.busy_o} !== 5'b10000) begin
            miscompares++;
            $display("FAIL abort_outputs: got ss,sclk,sdo,done,busy=%b required 10000",
                     {bus.ss_o, bus.sclk_o, bus.sdo_o, bus.done_o, bus.busy_o});
        end
        vectors++;
        if (bus.rx_data_o !== 8'h00) begin miscompares++; $display("FAIL abort_rx: got %h required 00", bus.rx_data_o); end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done_o !== 1'b0) done_seen++;
        end
        bus.en_i = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d bad cycles required 0", done_seen); end
    endtask

    initial begin
        bus.en_i = 1'b0;
        bus.tx_data_i = '0;
        test_reset();
        test_loopback();
        test_timing();
        test_early_drop();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer, MSB first; legal range 2..32.
REQ-002 Parameter HALF_DIV, default 2: clk_i cycles per SCLK half-period; legal range 1..255 (default gives 25 MHz SCLK from 100 MHz clk_i).
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 en_i  input  1  transfer enable; level-sensitive; while high, transfers repeat back-to-back.
REQ-006 tx_data_i  input  DATA_W  word to transmit; latched at transfer start.
REQ-007 sdi_i  input  1  serial data from slave (MISO).
REQ-008 sdo_o  output  1  serial data to slave (MOSI).
REQ-009 sclk_o  output  1  serial clock, SPI mode 0 (CPOL=0, CPHA=0).
REQ-010 ss_o  output  1  slave select, active low.
REQ-011 rx_data_o  output  DATA_W  last completed received word; held until the next completion.
REQ-012 done_o  output  1  one-cycle pulse when rx_data_o updates.
REQ-013 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, LEAD, SHIFT, TRAIL, GAP.
REQ-015 IDLE: ss_o=1, sclk_o=0, sdo_o=0; on a clk_i edge with en_i=1, latch tx_data_i and go to LEAD.
REQ-016 LEAD: ss_o=0, sclk_o=0, sdo_o=latched MSB; lasts HALF_DIV cycles, then go to SHIFT.
REQ-017 SHIFT: sclk_o toggles every HALF_DIV cycles, starting with a rising edge; exactly DATA_W rising edges and DATA_W falling edges are produced.
REQ-018 On each rising sclk_o edge, sdi_i SHALL be sampled into the receive shift register, MSB first.
REQ-019 On each falling sclk_o edge except the last, sdo_o SHALL advance to the next lower bit; after the last falling edge, go to TRAIL.
REQ-020 TRAIL: ss_o=0, sclk_o=0 for HALF_DIV cycles; on exit, rx_data_o is loaded, done_o pulses for one cycle, and the FSM goes to GAP with ss_o=1.
REQ-021 GAP: ss_o=1 for HALF_DIV cycles, then go to IDLE; a new transfer therefore starts no earlier than the cycle after GAP ends.
REQ-022 Dropping en_i mid-transfer SHALL NOT abort it; the transfer completes, and the FSM returns to IDLE and stays there while en_i=0.
REQ-023 Changes on tx_data_i during a transfer SHALL NOT affect it.
REQ-024 Frame length in clk_i cycles, from ss_o falling to ss_o rising, SHALL be HALF_DIV*(2*DATA_W+2).
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 While rst_ni=0: FSM=IDLE, ss_o=1, sclk_o=0, sdo_o=0, rx_data_o=0, done_o=0, busy_o=0, and all counters and shift registers cleared.
REQ-027 Reset asserted mid-transfer SHALL abort immediately with no done_o pulse.
REQ-028 After release, the first transfer starts on the first clk_i edge with en_i=1.

Structure
REQ-029 The FSM state enum and mode constants (CPOL/CPHA=0) SHALL reside in the shared package spi_pkg.
REQ-030 A sub-module spi_clk_div (half-period counter producing rise/fall strobes) SHALL be used; shift and FSM logic SHALL be in spi_master.

Verification
REQ-031 Reset scenario: rst_ni low with en_i high -> ss_o=1, sclk_o=0, sdo_o=0, done_o=0 throughout.
REQ-032 Loopback scenario: sdi_i tied to sdo_o, tx_data_i=0xA5, en_i pulsed -> sdo_o bits 1,0,1,0,0,1,0,1, and after done_o, rx_data_o=0xA5.
REQ-033 Timing scenario: HALF_DIV=2, DATA_W=8 -> ss_o low for 36 cycles, 8 SCLK periods of 4 cycles, first rise 2 cycles after ss_o falls.
REQ-034 Continuous scenario: en_i held high, tx_data_i=0x3C then 0xC3 -> two frames, each ss_o high gap exactly 2 cycles plus 1 IDLE cycle, two done_o pulses.
REQ-035 Early-drop scenario: en_i dropped after 3 SCLK rises -> frame completes, one done_o pulse, then IDLE.
REQ-036 Abort scenario: rst_ni asserted mid-SHIFT -> outputs return to reset values immediately, no done_o pulse, rx_data_o=0.
